// File: rtl/rename_tag_scheduler.sv
// -----------------------------------------------------------------------------
// rename_tag_scheduler
//
// Producer-tag allocator and register-status scoreboard between decode and
// dispatch. Each architectural register carries a valid bit and a tail tag
// naming its newest in-flight producer. Decode receives the operand status
// and the destination tag for an instruction in the same cycle. Result
// broadcasts retire tags and mark the registers waiting on them as ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   issue_valid / issue_ready  decode handshake (ready is combinational)
//   issue_ra1, issue_ra2       source register addresses
//   issue_wa, issue_wr         destination register and its write enable
//   rs1_valid/rs1_tag,
//   rs2_valid/rs2_tag          operand readiness, or the tag to wait on
//   alloc_tag                  tag given to the accepted result, 0 if none
//   cdb_valid, cdb_tag         result broadcast
//   flush                      discard every in-flight producer
//   free_count                 registered number of free tags
//   cdb_err                    registered pulse: broadcast of a tag not in use
// -----------------------------------------------------------------------------
module rename_tag_scheduler #(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_ra1,
    input  logic [4:0]       issue_ra2,
    input  logic [4:0]       issue_wa,
    input  logic             issue_wr,
    output logic             rs1_valid,
    output logic             rs2_valid,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             flush,
    output logic [7:0]       free_count,
    output logic             cdb_err
);

    logic [31:0]        valid_q, valid_d;
    logic [TAG_W-1:0]   tail_q [32];
    logic [TAG_W-1:0]   tail_d [32];
    logic [NUM_TAGS:1]  busy_q, busy_d;
    logic [7:0]         free_count_q, free_count_d;
    logic               cdb_err_q, cdb_err_d;

    logic               needs_tag;
    logic               do_alloc;
    logic               cdb_hit;
    logic [TAG_W-1:0]   free_tag;

    // x0 is never renamed, so valid_q[0] stays 1 and its lookup is always
    // "ready, tag 0" without a special case.
    assign needs_tag   = issue_wr & (issue_wa != 5'd0);
    assign issue_ready = !flush & ((free_count_q != 8'd0) | !needs_tag);
    assign do_alloc    = issue_valid & issue_ready & needs_tag;
    assign alloc_tag   = do_alloc ? free_tag : '0;

    // Operand lookup from pre-edge state, with a same-cycle broadcast bypass.
    // A valid register may hold a stale tail equal to cdb_tag; that is
    // harmless because it already reads as ready.
    assign rs1_valid = valid_q[issue_ra1] | (cdb_valid & (tail_q[issue_ra1] == cdb_tag));
    assign rs2_valid = valid_q[issue_ra2] | (cdb_valid & (tail_q[issue_ra2] == cdb_tag));
    assign rs1_tag   = rs1_valid ? '0 : tail_q[issue_ra1];
    assign rs2_tag   = rs2_valid ? '0 : tail_q[issue_ra2];

    assign free_count = free_count_q;
    assign cdb_err    = cdb_err_q;

    // Lowest-numbered free tag. When none is free, free_count_q is 0 and the
    // stall keeps the stale value from being used.
    always_comb begin
        free_tag = '0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!busy_q[i]) free_tag = TAG_W'(i);
        end
    end

    // A broadcast counts only for a tag in 1..NUM_TAGS that is currently busy.
    always_comb begin
        cdb_hit = 1'b0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (cdb_valid && (cdb_tag == TAG_W'(i)) && busy_q[i]) cdb_hit = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every _d signal takes its hold value first so that no path
        // through this block leaves it unassigned and infers a latch.
        valid_d      = valid_q;
        tail_d       = tail_q;
        busy_d       = busy_q;
        free_count_d = free_count_q;
        cdb_err_d    = 1'b0;

        if (flush) begin
            valid_d = '1;
            for (int r = 0; r < 32; r++) tail_d[r] = '0;
            busy_d       = '0;
            free_count_d = 8'(NUM_TAGS);
        end else begin
            cdb_err_d = cdb_valid & !cdb_hit;

            if (cdb_hit) begin
                for (int i = 1; i <= NUM_TAGS; i++) begin
                    if (cdb_tag == TAG_W'(i)) busy_d[i] = 1'b0;
                end
                for (int r = 0; r < 32; r++) begin
                    if (!valid_q[r] && (tail_q[r] == cdb_tag)) valid_d[r] = 1'b1;
                end
                free_count_d = free_count_d + 8'd1;
            end

            // The rename comes after the broadcast so that a destination whose
            // old producer is retiring this cycle still ends up pending on
            // the new tag. free_tag comes from pre-edge state, so a tag freed
            // this cycle cannot be handed out until the next one.
            if (do_alloc) begin
                for (int i = 1; i <= NUM_TAGS; i++) begin
                    if (free_tag == TAG_W'(i)) busy_d[i] = 1'b1;
                end
                valid_d[issue_wa] = 1'b0;
                tail_d[issue_wa]  = free_tag;
                free_count_d      = free_count_d - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '1;
            // NOTE: the tail array is architectural state that must read as
            // "no producer" straight after reset, so it is reset as well
            // instead of being left as an uninitialised memory.
            for (int r = 0; r < 32; r++) tail_q[r] <= '0;
            busy_q       <= '0;
            free_count_q <= 8'(NUM_TAGS);
            cdb_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge value of every other flop.
            valid_q      <= valid_d;
            tail_q       <= tail_d;
            busy_q       <= busy_d;
            free_count_q <= free_count_d;
            cdb_err_q    <= cdb_err_d;
        end
    end

endmodule
